en_reg_fifo: RTL
================

Name: en_reg_fifo

Overview:
- Synchronous FIFO, DEPTH words by WIDTH bits, one clock domain.
- Storage is an array of word-wide enable registers. A write-pointer decoder drives each word's load enable, so a word loads only when it is addressed and the write is accepted.
- Sits directly upstream of the memory read path. It consumes the per-word enable registers and produces buffered data plus flow-control flags for the producer.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 8: number of storage words. Must be a power of two, at least 2.
- ADDR_W, 3: pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  write request
- wr_data  input  WIDTH  write data
- rd_en  input  1  read request
- rd_data  output  WIDTH  registered read data
- rd_valid  output  1  rd_data was updated by the previous accepted read
- full  output  1  count equals DEPTH
- empty  output  1  count equals 0
- count  output  ADDR_W+1  words currently stored
- overflow  output  1  one-cycle pulse: write requested while full
- underflow  output  1  one-cycle pulse: read requested while empty

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. Everything else is synchronous to the rising edge of clk.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0, full=0, empty=1.
- Storage words have no reset. Their contents after reset are don't-care and are unreachable until written.
- Accept rules use pre-edge flags:
  - wr_acc = wr_en & !full
  - rd_acc = rd_en & !empty
- Write path:
  - On wr_acc, word[wr_ptr] loads wr_data.
  - Load enable of word i = wr_acc & (wr_ptr == i). At most one enable is high per cycle.
  - wr_ptr increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- Read path:
  - On rd_acc, rd_data <= word[rd_ptr] and rd_ptr increments modulo DEPTH. Latency is 1 cycle.
  - rd_valid = registered rd_acc.
  - rd_data holds its value when there is no rd_acc.
- Count update:
  - +1 on wr_acc & !rd_acc.
  - -1 on rd_acc & !wr_acc.
  - Unchanged when both or neither are accepted.
- full and empty are decoded from the registered count. They are combinational from flops only, with no path from wr_en or rd_en.
- Simultaneous requests:
  - Empty, wr_en and rd_en together: the write is accepted, the read is rejected and underflow pulses. The written word is readable the next cycle. There is no bypass.
  - Full, wr_en and rd_en together: the read is accepted, the write is rejected and overflow pulses. count goes to DEPTH-1.
  - Neither full nor empty: both are accepted, count is unchanged, and the pointers advance independently.
- Flag pulses: overflow = registered (wr_en & full); underflow = registered (rd_en & empty). Each is a one-cycle pulse per offending request cycle.
- Rejected operations leave storage, pointers and count unchanged.
- Reset mid-operation: asserting rst clears pointers, count, flags and rd_data immediately, without waiting for a clock edge. Queued data is discarded.

Decomposition:
- Shared package fifo_pkg holds:
  - default constants FIFO_WIDTH=8, FIFO_DEPTH=8, FIFO_ADDR_W=3;
  - a function clog2 for ADDR_W derivation;
  - the count width constant.
- Sub-module en_register: a WIDTH-bit register with a load enable (q <= en ? d : q) and no reset. It is instantiated DEPTH times under a generate loop, one instance per storage word.
- Top level contains:
  - the write decoder;
  - the read mux;
  - the pointer and count logic;
  - the flag registers.

Test Plan:
- Reset then idle: assert rst for 2 cycles -> empty=1, full=0, count=0, rd_data=0, no overflow or underflow pulses.
- Fill and drain:
  - Write 0x11..0x88 on 8 consecutive cycles -> full=1, count=8.
  - Then read 8 cycles -> rd_data 0x11,0x22,...,0x88 in order, each one cycle after its rd_en, rd_valid=1 each cycle.
  - Finally empty=1.
- Wrap-around:
  - Write 5, read 5, then write 6 more (0xA0..0xA5) and read them back.
  - Required: data in order, count peaks at 6, wr_ptr passes 7->0 without loss.
- Boundary collisions:
  - Full with wr_en=rd_en=1 -> overflow pulses, oldest word read, count=7.
  - Empty with both set and wr_data=0x5C -> underflow pulses, count=1; next-cycle read returns 0x5C.
- Steady streaming: with count=3, apply wr_en=rd_en=1 for 10 cycles -> count stays 3, output order preserved, no flag pulses.
- Reset mid-operation: with 4 words stored, pulse rst between clock edges -> flags and count clear before the next edge; a subsequent read gives underflow=1, rd_valid=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the enable-register FIFO.
package fifo_pkg;
  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int FIFO_ADDR_W = clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W  = FIFO_ADDR_W + 1;
endpackage

// File: rtl/en_register.sv
// Word-wide storage register; loads only when en is high, no reset by design.
module en_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (en) q <= d;
endmodule

// File: rtl/en_reg_fifo.sv
// Synchronous FIFO built from per-word enable registers, with registered read
// data and one-cycle overflow/underflow pulses.
module en_reg_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            ld;
  logic [ADDR_W-1:0]           wr_ptr, rd_ptr;
  logic                        wr_acc, rd_acc;

  // Flags come from the registered count only, never from the requests.
  assign full   = (count == (ADDR_W+1)'(DEPTH));
  assign empty  = (count == '0);
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign ld[i] = wr_acc & (wr_ptr == ADDR_W'(i));
    en_register #(.WIDTH(WIDTH)) u_word (
      .clk (clk),
      .en  (ld[i]),
      .d   (wr_data),
      .q   (mem[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      rd_valid  <= rd_acc;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end
endmodule
